// File: rtl/cp0_irq_if.sv
// Bus between the M stage and the CP0 exception/interrupt unit.
// The pipeline side is the master; cp0_irq is the slave.
interface cp0_irq_if;
  logic [4:0]  a;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] vpc;
  logic        bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc;
  logic        exl;

  modport master (
    output a, we, din, vpc, bd, exc_valid, exc_code, hw_int, eret,
    input  dout, req, epc, exl
  );

  modport slave (
    input  a, we, din, vpc, bd, exc_valid, exc_code, hw_int, eret,
    output dout, req, epc, exl
  );
endinterface

// File: rtl/cp0_irq.sv
// Coprocessor-0 exception and interrupt unit.
// Holds SR, Cause, EPC and PRId, and decides each cycle whether the M-stage
// instruction is taken by an interrupt or an exception.
module cp0_irq #(
  parameter logic [31:0] PRID = 32'h0000_2021
) (
  input logic        clk,
  input logic        reset,
  cp0_irq_if.slave   bus
);

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  // EPC
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_vpc_aligned;
  logic [31:0] w_exc_epc;
  logic [31:0] w_din_aligned;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unused_vpc;

  // The low PC bits never matter: EPC is always word aligned.
  assign w_unused_vpc = ^bus.vpc[1:0];

  // Request decision: purely combinational so the M stage is flushed in the
  // same cycle the condition appears. Interrupts win over exceptions.
  assign w_int_req = (|(bus.hw_int & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = bus.exc_valid & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  // A delay-slot victim must restart at its branch, one word earlier.
  assign w_vpc_aligned = {bus.vpc[31:2], 2'b00};
  assign w_exc_epc     = bus.bd ? (w_vpc_aligned - 32'd4) : w_vpc_aligned;
  assign w_din_aligned = {bus.din[31:2], 2'b00};

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b00};

  // Register state: exception entry, eret and mtc0 updates; IP samples hw_int.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= bus.hw_int;
      if (w_req) begin
        // The victim does not commit, so its mtc0/eret are dropped.
        r_exl      <= 1'b1;
        r_exc_code <= w_int_req ? 5'd0 : bus.exc_code;
        r_bd       <= bus.bd;
        r_epc      <= w_exc_epc;
      end else begin
        if (bus.we) begin
          case (bus.a)
            A_SR: begin
              r_im  <= bus.din[15:10];
              r_exl <= bus.din[1];
              r_ie  <= bus.din[0];
            end
            A_EPC:   r_epc <= w_din_aligned;
            default: ;
          endcase
        end
        // Placed after the write so eret wins the EXL bit when both occur.
        if (bus.eret) r_exl <= 1'b0;
      end
    end
  end

  // mfc0 read mux over the current register values.
  always_comb begin
    // NOTE: default first so every path assigns dout and no latch is inferred.
    bus.dout = 32'd0;
    case (bus.a)
      A_SR:    bus.dout = w_sr;
      A_CAUSE: bus.dout = w_cause;
      A_EPC:   bus.dout = r_epc;
      A_PRID:  bus.dout = PRID;
      default: bus.dout = 32'd0;
    endcase
  end

  // EPC bypass lets an eret right behind an mtc0 EPC return to the new value.
  assign bus.epc = (bus.we && (bus.a == A_EPC)) ? w_din_aligned : r_epc;
  assign bus.req = w_req;
  assign bus.exl = r_exl;

endmodule

// File: tb/tb_cp0_irq.sv
// Directed bench for cp0_irq. The stimulus process queues the expected
// output values for each cycle; a monitor on the falling edge pops and
// compares them.
module tb_cp0_irq;

  localparam logic [31:0] PRID = 32'h0000_2021;

  typedef enum logic [1:0] {S_DOUT, S_REQ, S_EPC, S_EXL} sig_e;

  typedef struct {
    int          cyc;
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   stim_done;
  exp_t q[$];

  cp0_irq_if bus ();

  cp0_irq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_checks++;
    if (act !== req_val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req_val, cyc);
    end
  endtask

  task automatic ex(input string name, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    q.push_back(e);
  endtask

  // Advance one cycle and return the pulsed inputs to idle; hw_int is held.
  task automatic nxt();
    @(posedge clk);
    #1;
    bus.a         = 5'd0;
    bus.we        = 1'b0;
    bus.din       = 32'd0;
    bus.vpc       = 32'd0;
    bus.bd        = 1'b0;
    bus.exc_valid = 1'b0;
    bus.exc_code  = 5'd0;
    bus.eret      = 1'b0;
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.sig)
        S_DOUT:  act = bus.dout;
        S_REQ:   act = {31'd0, bus.req};
        S_EPC:   act = bus.epc;
        default: act = {31'd0, bus.exl};
      endcase
      if (e.cyc != cyc) check({e.name, " (stale)"}, 32'hDEAD_DEAD, e.val);
      else              check(e.name, act, e.val);
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    stim_done = 1'b0;
    reset     = 1'b1;
    bus.hw_int = 6'd0;
    nxt();
    nxt();
    nxt();
    reset = 1'b0;

    // Reset state
    bus.a = 5'd12; ex("rst_sr", S_DOUT, 32'd0); ex("rst_req", S_REQ, 0);
    ex("rst_exl", S_EXL, 0); ex("rst_epc", S_EPC, 32'd0);
    nxt(); bus.a = 5'd13; ex("rst_cause", S_DOUT, 32'd0);
    nxt(); bus.a = 5'd14; ex("rst_epcreg", S_DOUT, 32'd0);
    nxt(); bus.a = 5'd15; ex("rst_prid", S_DOUT, PRID);
    nxt(); bus.a = 5'd7;  ex("rst_other", S_DOUT, 32'd0);

    // Timer interrupt
    nxt(); bus.we = 1'b1; bus.a = 5'd12; bus.din = 32'h0000_0401; ex("tmr_wr_req", S_REQ, 0);
    nxt(); bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3010; bus.a = 5'd12;
    ex("tmr_req", S_REQ, 1); ex("tmr_sr", S_DOUT, 32'h0000_0401);
    nxt(); bus.a = 5'd14;
    ex("tmr_epc", S_DOUT, 32'h0000_3010); ex("tmr_req_masked", S_REQ, 0);
    ex("tmr_exl", S_EXL, 1); ex("tmr_epc_out", S_EPC, 32'h0000_3010);
    nxt(); bus.a = 5'd13; ex("tmr_cause", S_DOUT, 32'h0000_0400);
    nxt(); bus.a = 5'd12; ex("tmr_sr_exl", S_DOUT, 32'h0000_0403);
    bus.hw_int = 6'd0; bus.eret = 1'b1; ex("tmr_eret_req", S_REQ, 0);
    nxt(); bus.a = 5'd12; ex("tmr_sr_after", S_DOUT, 32'h0000_0401); ex("tmr_exl_clr", S_EXL, 0);

    // Exception in a delay slot
    nxt(); bus.we = 1'b1; bus.a = 5'd12; bus.din = 32'd0;
    nxt(); bus.exc_valid = 1'b1; bus.exc_code = 5'd10; bus.vpc = 32'h0000_3008; bus.bd = 1'b1;
    ex("ds_req", S_REQ, 1);
    nxt(); bus.a = 5'd14; ex("ds_epc", S_DOUT, 32'h0000_3004);
    nxt(); bus.a = 5'd13; ex("ds_cause", S_DOUT, 32'h8000_0028);
    bus.exc_valid = 1'b1; bus.exc_code = 5'd3; ex("ds_nested_masked", S_REQ, 0);
    nxt(); bus.a = 5'd13; ex("ds_cause_kept", S_DOUT, 32'h8000_0028); bus.eret = 1'b1;

    // Simultaneous interrupt and exception, mtc0 EPC discarded
    nxt(); bus.we = 1'b1; bus.a = 5'd12; bus.din = 32'h0000_1001;
    nxt(); bus.hw_int = 6'b000100; bus.exc_valid = 1'b1; bus.exc_code = 5'd4;
    bus.vpc = 32'h0000_4000; bus.we = 1'b1; bus.a = 5'd14; bus.din = 32'h0000_1234;
    ex("sim_req", S_REQ, 1); ex("sim_epc_bypass", S_EPC, 32'h0000_1234);
    nxt(); bus.hw_int = 6'd0; bus.a = 5'd14; ex("sim_epc", S_DOUT, 32'h0000_4000);
    nxt(); bus.a = 5'd13; ex("sim_cause", S_DOUT, 32'h0000_0000);

    // eret together with mtc0 EPC
    nxt(); bus.we = 1'b1; bus.a = 5'd14; bus.din = 32'h0000_3103; bus.eret = 1'b1;
    ex("eret_epc_bypass", S_EPC, 32'h0000_3100); ex("eret_req", S_REQ, 0);
    nxt(); bus.a = 5'd14; ex("eret_epcreg", S_DOUT, 32'h0000_3100);
    ex("eret_exl", S_EXL, 0); ex("eret_epc_out", S_EPC, 32'h0000_3100);

    // mtc0 SR with EXL set plus eret: EXL ends at 0
    nxt(); bus.we = 1'b1; bus.a = 5'd12; bus.din = 32'h0000_0003; bus.eret = 1'b1;
    nxt(); bus.a = 5'd12; ex("sr_eret", S_DOUT, 32'h0000_0001);

    // EPC wrap-around
    nxt(); bus.exc_valid = 1'b1; bus.exc_code = 5'd12; bus.bd = 1'b1; bus.vpc = 32'd0;
    ex("wrap_req", S_REQ, 1);
    nxt(); bus.a = 5'd14; ex("wrap_epc", S_DOUT, 32'hFFFF_FFFC); ex("wrap_exl", S_EXL, 1);
    bus.eret = 1'b1;

    // Masked line, then Cause write ignored
    nxt(); bus.hw_int = 6'b000010; ex("mask_req", S_REQ, 0);
    nxt(); bus.a = 5'd13; ex("mask_ip", S_DOUT, 32'h8000_0830); ex("mask_req2", S_REQ, 0);
    bus.we = 1'b1; bus.din = 32'hFFFF_FFFF;
    nxt(); bus.a = 5'd13; ex("cause_ro", S_DOUT, 32'h8000_0830);

    // Level-sensitive re-interrupt after eret
    nxt(); bus.we = 1'b1; bus.a = 5'd12; bus.din = 32'h0000_0801;
    nxt(); ex("lvl_req", S_REQ, 1);
    nxt(); ex("lvl_masked", S_REQ, 0); bus.eret = 1'b1;
    nxt(); ex("lvl_reint", S_REQ, 1);

    // Reset mid-handler
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; bus.a = 5'd12;
    ex("rst_mid_sr", S_DOUT, 32'd0); ex("rst_mid_exl", S_EXL, 0); ex("rst_mid_req", S_REQ, 0);
    nxt();
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cp0_irq.md
# cp0_irq

Coprocessor-0 exception and interrupt unit for the pipelined MIPS CPU. It collects the hardware interrupt lines from the timers and the external source. It also holds the SR, Cause, EPC and PRId registers for mfc0/mtc0, and decides each cycle whether the instruction in the commit (M) stage is taken by an interrupt or exception. It sits beside the M stage; its request flushes the pipeline and redirects fetch to the handler, and eret redirects fetch to EPC.

## Interface
- PRID, 32'h0000_2021, read-only value returned for register 15.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- a  in  5  CP0 register number for mfc0/mtc0.
- we  in  1  mtc0 write enable.
- din  in  32  mtc0 write data.
- dout  out  32  mfc0 read data.
- vpc  in  32  PC of the M-stage instruction.
- bd  in  1  M-stage instruction is in a branch delay slot.
- exc_valid  in  1  M-stage instruction raised an exception.
- exc_code  in  5  exception code, valid with exc_valid.
- hw_int  in  6  interrupt lines: [0] timer 0, [1] timer 1, [2] external, [5:3] tied 0.
- eret  in  1  M-stage instruction is eret.
- req  out  1  take interrupt/exception this cycle.
- epc  out  32  return address for eret.
- exl  out  1  SR.EXL.

## Operation
Register fields:
- SR (12): IM = [15:10], EXL = [1], IE = [0]. All other bits read 0 and ignore writes.
- Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0.
  - Cause is read-only to mtc0; writes are ignored.
- EPC (14): read/write. A write stores {din[31:2], 2'b00}.
- PRId (15): read-only, returns PRID.
- Any other a: reads 0, writes ignored.

Request logic (combinational):
- int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- exc_req = exc_valid & ~SR.EXL.
- req = int_req | exc_req.
- When both are pending, the interrupt has priority over the exception.

On a clock edge with req=1:
- SR.EXL <= 1.
- Cause.ExcCode <= int_req ? 5'd0 : exc_code.
- Cause.BD <= bd.
- EPC <= bd ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}, modulo 2^32.
- Any mtc0 in the same cycle is discarded, because the victim instruction does not commit.
- eret in the same cycle is ignored.

On a clock edge with eret=1 and req=0:
- SR.EXL <= 0.

On a clock edge with we=1, req=0 and a write to a valid address:
- The register field update described above.
- If we and eret coincide, the mtc0 write is applied and EXL is then cleared.
  - For a=12, EXL ends at 0.
  - All other bits come from din.

Cause.IP:
- Cause.IP <= hw_int on every clock, independent of req, we and EXL.

Outputs:
- dout: combinational read of the register selected by a, from current register values.
- epc: if we=1 and a=14, epc = {din[31:2],2'b00}; otherwise epc = EPC. This bypass lets eret directly after mtc0 EPC return correctly.
- exl = SR.EXL.

While EXL=1, all interrupts and exceptions are masked. Nested exceptions are not supported.

## Timing
Reset:
- SR, Cause and EPC are all 0.
- Consequently req=0, exl=0 and epc=0.
- dout = 0 for every a except 15, which returns PRID.

Latencies:
- req responds in the same cycle as hw_int, exc_valid or an SR change. There is zero latency from inputs to req.
- Register updates from req, eret or mtc0 are visible on dout one cycle after the edge.
- IP lags hw_int by one cycle on dout. req uses the live hw_int, not IP.

Level sensitivity:
- hw_int is level-sensitive. The interrupt source must hold it until software clears it at the device.
- A line still high after eret re-interrupts on the first cycle with EXL=0.

Reset mid-handler:
- A reset with EXL=1 clears EXL and masks all interrupts; there is no pending state.

## Test plan
- Reset, read all registers:
  - Expected: a=12/13/14 read 0, a=15 reads 32'h0000_2021, req=0.
- Timer interrupt:
  - Stimulus: mtc0 SR=32'h0000_0401, then hw_int=6'b000001 with vpc=32'h0000_3010, bd=0.
  - Expected: req=1 that cycle. Next cycle EPC=32'h0000_3010, ExcCode=0, EXL=1, req=0 while hw_int remains high.
- Exception in a delay slot:
  - Stimulus: SR.IE=0, exc_valid=1, exc_code=5'd10, vpc=32'h0000_3008, bd=1.
  - Expected: EPC=32'h0000_3004, Cause=32'h8000_0028. Cause.IP is 0 here; its bits [15:10] track hw_int.
- Simultaneous interrupt and exception:
  - Stimulus: hw_int=6'b000100 enabled, exc_valid=1, exc_code=5'd4.
  - Expected: ExcCode=0; a same-cycle mtc0 EPC=32'h1234 is discarded.
- eret after mtc0 EPC:
  - Stimulus: with EXL=1, mtc0 EPC=32'h0000_3103 and eret in the same cycle.
  - Expected: epc=32'h0000_3100 that cycle. Next cycle EXL=0 and EPC=32'h0000_3100.
- EPC wrap-around and a masked line:
  - Stimulus: bd=1, vpc=0, exc_valid=1.
  - Expected: EPC=32'hFFFF_FFFC.
  - Stimulus: hw_int=6'b000010 with IM[11]=0.
  - Expected: req stays 0, and IP bit 11 reads 1 one cycle later.
